// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: pause levels, bus widths, FSM states.
package if_fetch_unit_pkg;

  localparam logic PAUSE_ENABLE  = 1'b1;
  localparam logic PAUSE_DISABLE = 1'b0;

  localparam int IF_ADDR_WIDTH = 16;
  localparam int IF_INST_WIDTH = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Two-entry instruction FIFO feeding IF/ID; slot0 is always the head so outputs come straight from flops.
module fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
  parameter int INST_WIDTH = IF_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [INST_WIDTH-1:0] push_inst,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic                  head_vld,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [INST_WIDTH-1:0] head_inst
);

  logic [1:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] slot0_pc_q, slot0_pc_d, slot1_pc_q, slot1_pc_d;
  logic [INST_WIDTH-1:0] slot0_inst_q, slot0_inst_d, slot1_inst_q, slot1_inst_d;
  logic                  do_pop;

  assign do_pop = pop && (count_q != 2'd0);

  always_comb begin
    count_d      = count_q;
    slot0_pc_d   = slot0_pc_q;
    slot0_inst_d = slot0_inst_q;
    slot1_pc_d   = slot1_pc_q;
    slot1_inst_d = slot1_inst_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_pc_d   = push_pc;
            slot0_inst_d = push_inst;
          end else begin
            slot1_pc_d   = push_pc;
            slot1_inst_d = push_inst;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_pc_d   = slot1_pc_q;
          slot0_inst_d = slot1_inst_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: new entry lands behind whatever survives the pop.
          if (count_q == 2'd2) begin
            slot0_pc_d   = slot1_pc_q;
            slot0_inst_d = slot1_inst_q;
            slot1_pc_d   = push_pc;
            slot1_inst_d = push_inst;
          end else begin
            slot0_pc_d   = push_pc;
            slot0_inst_d = push_inst;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      slot0_pc_q   <= '0;
      slot0_inst_q <= '0;
      slot1_pc_q   <= '0;
      slot1_inst_q <= '0;
    end else begin
      count_q      <= count_d;
      slot0_pc_q   <= slot0_pc_d;
      slot0_inst_q <= slot0_inst_d;
      slot1_pc_q   <= slot1_pc_d;
      slot1_inst_q <= slot1_inst_d;
    end
  end

  assign count     = count_q;
  assign head_vld  = (count_q != 2'd0);
  assign head_pc   = slot0_pc_q;
  assign head_inst = slot0_inst_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack handshake to instruction memory, 2-deep buffer toward IF/ID.
// Redirects flush the buffer; an in-flight request is tracked in KILL so its ack is dropped.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                  ADDR_WIDTH = IF_ADDR_WIDTH,
  parameter int                  INST_WIDTH = IF_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_pause,
  input  logic                  if_id_pause,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [1:0]            buf_count, remain;
  logic                  consume, push, pop, fetch_ok;

  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign consume  = if_valid && (if_id_pause != PAUSE_ENABLE);
  assign pop      = consume && !branch_en;
  assign remain   = buf_count - {1'b0, consume};
  assign fetch_ok = (pc_pause == PAUSE_DISABLE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (branch_en) begin
          pc_d = branch_target;
        end else if (fetch_ok && (buf_count != 2'd2)) begin
          req_addr_d = pc_q;
          state_d    = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          if (branch_en) begin
            pc_d    = branch_target;
            state_d = FETCH_IDLE;
          end else begin
            push = 1'b1;
            pc_d = pc_inc;
            // Chain only when the buffer will hold just this word, so the next ack always has room.
            if (fetch_ok && (remain == 2'd0)) begin
              req_addr_d = pc_inc;
            end else begin
              state_d = FETCH_IDLE;
            end
          end
        end else if (branch_en) begin
          pc_d    = branch_target;
          state_d = FETCH_KILL;
        end
      end
      FETCH_KILL: begin
        if (branch_en) begin
          pc_d = branch_target;
        end
        if (imem_ack) begin
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req  = (state_q != FETCH_IDLE);
  assign imem_addr = req_addr_q;

  fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_pc   (req_addr_q),
    .push_inst (imem_rdata),
    .pop       (pop),
    .flush     (branch_en),
    .count     (buf_count),
    .head_vld  (if_valid),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected (pc, inst) pairs checked on every consumed head.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, pc_pause, if_id_pause, branch_en;
  logic [15:0] branch_target;
  logic        imem_req, imem_ack, if_valid;
  logic [15:0] imem_addr, imem_rdata, if_inst, if_pc;
  logic        zero_wait, ack_drv;

  logic        imem2_req, if_valid2;
  logic [15:0] imem2_addr, imem2_rdata, if_inst2, if_pc2;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign imem_ack    = zero_wait ? imem_req : ack_drv;
  assign imem_rdata  = inst_of(imem_addr);
  assign imem2_rdata = inst_of(imem2_addr);

  if_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .pc_pause(pc_pause), .if_id_pause(if_id_pause),
    .branch_en(branch_en), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  if_fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_pause(1'b0), .if_id_pause(1'b0),
    .branch_en(1'b0), .branch_target(16'h0000),
    .imem_req(imem2_req), .imem_addr(imem2_addr), .imem_ack(imem2_req), .imem_rdata(imem2_rdata),
    .if_valid(if_valid2), .if_inst(if_inst2), .if_pc(if_pc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = start + 16'(i);
      e.inst = inst_of(e.pc);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    branch_en     = 1'b0;
    branch_target = 16'h0000;
    zero_wait     = 1'b1;
    ack_drv       = 1'b0;
    sb_q.delete();
    repeat (2) tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Every head that IF/ID actually takes must be the next expected instruction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && if_valid && !if_id_pause && !branch_en) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got pc %h inst %h, expected none", if_pc, if_inst);
      end else begin
        e = sb_q.pop_front();
        chk("mon_pc", 32'(if_pc), 32'(e.pc));
        chk("mon_inst", 32'(if_inst), 32'(e.inst));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", 32'(if_inst), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_addr_wrap", 32'(imem2_addr), 32'd0);

    // zero-wait streaming
    expect_seq(16'h0000, 8);
    rst_n = 1'b1;
    tick();
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", 32'(imem_addr), 32'd0);
    chk("t1_valid_early", 32'(if_valid), 32'd0);
    tick();
    chk("t1_valid_rise", 32'(if_valid), 32'd1);
    chk("t1_b2b_addr", 32'(imem_addr), 32'd1);
    drain("t1_drain");

    // IF/ID stall fills the buffer and stops fetching
    do_reset();
    expect_seq(16'h0000, 8);
    rst_n = 1'b1;
    tick();
    tick();
    if_id_pause = 1'b1;
    tick();
    chk("t2_req_drop", 32'(imem_req), 32'd0);
    chk("t2_pc_hold_a", 32'(if_pc), 32'd0);
    tick();
    tick();
    chk("t2_pc_hold_b", 32'(if_pc), 32'd0);
    chk("t2_valid_hold", 32'(if_valid), 32'd1);
    tick();
    if_id_pause = 1'b0;
    drain("t2_drain");

    // redirect while a slow request is outstanding
    do_reset();
    zero_wait = 1'b0;
    expect_seq(16'h0040, 3);
    rst_n = 1'b1;
    tick();
    chk("t3_req", 32'(imem_req), 32'd1);
    branch_en     = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_en = 1'b0;
    chk("t3_kill_req", 32'(imem_req), 32'd1);
    chk("t3_kill_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("t3_kill_wait", 32'(imem_req), 32'd1);
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    chk("t3_idle_after_kill", 32'(imem_req), 32'd0);
    chk("t3_stale_dropped", 32'(if_valid), 32'd0);
    tick();
    chk("t3_new_req", 32'(imem_req), 32'd1);
    chk("t3_new_addr", 32'(imem_addr), 32'h0040);
    zero_wait = 1'b1;
    drain("t3_drain");

    // redirect coinciding with ack
    do_reset();
    expect_seq(16'h0100, 3);
    rst_n = 1'b1;
    tick();
    tick();
    branch_en     = 1'b1;
    branch_target = 16'h0100;
    tick();
    branch_en = 1'b0;
    chk("t4_flushed", 32'(if_valid), 32'd0);
    chk("t4_idle", 32'(imem_req), 32'd0);
    tick();
    chk("t4_new_addr", 32'(imem_addr), 32'h0100);
    drain("t4_drain");

    // PC wraps from a high reset vector
    do_reset();
    zero_wait = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t5_req_addr", 32'(imem2_addr), 32'hFFFE);
    tick();
    chk("t5_pc0", 32'(if_pc2), 32'hFFFE);
    chk("t5_inst0", 32'(if_inst2), 32'(inst_of(16'hFFFE)));
    tick();
    chk("t5_pc1", 32'(if_pc2), 32'hFFFF);
    tick();
    chk("t5_pc2", 32'(if_pc2), 32'h0000);
    chk("t5_inst2", 32'(if_inst2), 32'(inst_of(16'h0000)));

    // PC stall: current fetch completes, nothing new until release
    do_reset();
    expect_seq(16'h0000, 6);
    rst_n = 1'b1;
    tick();
    tick();
    pc_pause = 1'b1;
    tick();
    chk("t6_no_req_a", 32'(imem_req), 32'd0);
    tick();
    tick();
    chk("t6_no_req_b", 32'(imem_req), 32'd0);
    chk("t6_drained", 32'(if_valid), 32'd0);
    tick();
    tick();
    pc_pause = 1'b0;
    tick();
    chk("t6_resume_req", 32'(imem_req), 32'd1);
    chk("t6_resume_addr", 32'(imem_addr), 32'd2);
    drain("t6_drain");

    // async reset mid-request, ack without request ignored
    do_reset();
    zero_wait = 1'b0;
    expect_seq(16'h0000, 3);
    rst_n = 1'b1;
    tick();
    chk("t7_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_async_drop", 32'(imem_req), 32'd0);
    ack_drv = 1'b1;
    tick();
    tick();
    chk("t7_valid_in_rst", 32'(if_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t7_ack_ignored", 32'(if_valid), 32'd0);
    chk("t7_req_again", 32'(imem_req), 32'd1);
    drain("t7_drain");

    rst_n = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: owns the PC, runs a req/ack handshake to instruction memory, and buffers up to two fetched instructions for the IF/ID register. It sits directly upstream of the IF/ID register and consumes the `PC_pause` and `if_id_pause` stall signals from the pause controller, plus branch redirects from later stages. Stalls hold the fetch stream without losing or duplicating instructions. Redirects flush the stream, including any in-flight memory access.

## Interface
- `ADDR_WIDTH`, 16, PC and instruction-memory address width (word address)
- `INST_WIDTH`, 16, instruction width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc_pause`  in  1  from pause controller; at `PAUSE_ENABLE`, no new fetch is issued
- `if_id_pause`  in  1  from pause controller; at `PAUSE_ENABLE`, IF/ID does not take the head instruction
- `branch_en`  in  1  redirect request
- `branch_target`  in  ADDR_WIDTH  redirect PC
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_WIDTH  fetch address
- `imem_ack`  in  1  data valid; may assert in the same cycle as `imem_req`
- `imem_rdata`  in  INST_WIDTH  fetched instruction
- `if_valid`  out  1  head instruction present
- `if_inst`  out  INST_WIDTH  head instruction
- `if_pc`  out  ADDR_WIDTH  PC of head instruction

## Operation
- Derived signals:
  - consume = `if_valid` & (`if_id_pause` != `PAUSE_ENABLE`).
  - count = number of buffered instructions, 0..2.
- FSM states:
  - IDLE: no request.
  - REQ: request outstanding; `imem_req`=1.
  - KILL: request outstanding but redirected; `imem_req`=1, ack data is discarded.
- `imem_addr` = `req_addr` register, latched when a request is issued. It is stable while `imem_req`=1.
- An ack is honoured only when `imem_req`=1.
- IDLE transitions:
  - `branch_en`: pc<=`branch_target`, flush the buffer, stay IDLE.
  - Otherwise, if not `pc_pause` and count<2: `req_addr`<=pc, go to REQ.
- REQ, on ack without `branch_en`:
  - Push `imem_rdata` with PC `req_addr` into the buffer.
  - pc<=pc+1.
  - If not `pc_pause` and (count − consume)==0: `req_addr`<=pc+1, stay REQ (back-to-back fetch).
  - Else go to IDLE.
- REQ, no ack:
  - Stay REQ.
  - `branch_en`: pc<=target, flush, go to KILL.
- REQ, ack and `branch_en` in the same cycle: discard data, pc<=target, flush, go to IDLE.
- KILL:
  - On ack: discard data, go to IDLE.
  - `branch_en` in KILL (with or without ack): pc<=target, flush again, state unchanged unless ack.
- Buffer is a 2-entry FIFO; head drives `if_inst`/`if_pc`.
  - Push and consume in the same cycle is legal.
  - Push never occurs at count=2; the issue rules guarantee this.
- `branch_en` has priority over both pause inputs and over consume.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 = 0x0000.

## Timing
- Reset values:
  - state IDLE, pc=`RESET_PC`, count 0.
  - `imem_req`=0, `imem_addr`=0.
  - `if_valid`=0, `if_inst`=0, `if_pc`=0.
- Asserting `rst_n` low mid-request drops `imem_req` immediately (asynchronous), and any later ack is ignored.
- First request is issued in the 2nd cycle after reset release.
- Zero-wait memory:
  - `if_valid` rises 1 cycle after the first ack.
  - Steady state is 1 instruction/cycle with no pauses.
- Outputs `if_valid`/`if_inst`/`if_pc` are registered and change only on clock edges. They are unchanged while `if_id_pause` is at `PAUSE_ENABLE`, except on flush.
- Flush clears `if_valid` on the next edge.
- The first post-redirect instruction appears ≥2 cycles after `branch_en`.

## Structure
- Shared definitions file: `PAUSE_ENABLE`/`PAUSE_DISABLE`, FSM state encodings, `ADDR_WIDTH`/`INST_WIDTH` bus macros.
- One sub-module: `fetch_buffer`, a 2-entry FIFO with push/pop/flush and count output, no bypass.
- FSM, PC, and `req_addr` live in the top level.

## Test plan
- Zero-wait memory: release reset, hold ack=1 whenever req=1 → requests at addresses 0,1,2,… on consecutive cycles; `if_pc`=0,1,2,… on consecutive cycles from the 3rd cycle after release.
- `if_id_pause` held for 4 cycles with zero-wait memory → count reaches 2, `imem_req` drops, `if_pc` holds. After release, `if_pc` continues +1 per cycle with no gap or repeat.
- Ack delayed 3 cycles; `branch_en`=1, target 0x0040, in the cycle after the request issues → FSM goes to KILL and `imem_req` stays high at the old address. The stale ack is discarded, the next request is to 0x0040, and the first valid `if_pc` is 0x0040.
- `branch_en` in the same cycle as ack → that data never appears on `if_inst`, and the next request is to the target.
- `RESET_PC`=0xFFFE → fetched PCs 0xFFFE, 0xFFFF, 0x0000.
- `pc_pause` at `PAUSE_ENABLE` for 5 cycles with `if_id_pause` off → no new request is issued after the current one completes; fetch resumes the cycle after release at the next sequential PC.
